// File: rtl/inference_ctrl.sv
// Inference run controller: launches the encoder, times the run, captures the first
// output spike from the core (4-phase AER handshake) and counts delivered input events.
module inference_ctrl #(
  parameter int ADDR_BITS = 8,
  parameter int CNT_BITS  = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [CNT_BITS-1:0]  TIMEOUT_CYCLES,
  output logic                 NEW_IMAGE,
  input  logic                 IMAGE_ENCODED,
  output logic                 INFERENCE_DONE,
  input  logic                 AERIN_REQ,
  input  logic                 AERIN_ACK,
  input  logic                 AEROUT_REQ,
  input  logic [ADDR_BITS-1:0] AEROUT_ADDR,
  output logic                 AEROUT_ACK,
  output logic                 BUSY,
  output logic [ADDR_BITS-1:0] RESULT,
  output logic                 RESULT_VALID,
  output logic                 TIMED_OUT,
  output logic [8:0]           SPIKE_COUNT,
  output logic [CNT_BITS-1:0]  LATENCY
);

  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, ACK_HI, FINISH, DRAIN} state_t;

  state_t state, state_n;
  logic   aerin_ack_q;
  logic   timeout_hit;
  logic   spike_in;

  // Encoder status and the snooped request are observation-only; a run ends on a
  // core output spike or the timeout, never on encoder completion.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, IMAGE_ENCODED, AERIN_REQ};

  assign BUSY        = (state != IDLE);
  assign timeout_hit = (state == RUN) && (TIMEOUT_CYCLES != '0) &&
                       (LATENCY == TIMEOUT_CYCLES - CNT_BITS'(1));
  assign spike_in    = ((state == RUN) || (state == ACK_HI)) && AERIN_ACK && !aerin_ack_q;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (START) state_n = LAUNCH;
               else if (AEROUT_REQ) state_n = DRAIN;
      LAUNCH:  state_n = RUN;
      // a spike arriving in the timeout cycle takes precedence
      RUN:     if (AEROUT_REQ) state_n = ACK_HI;
               else if (timeout_hit) state_n = FINISH;
      ACK_HI:  if (!AEROUT_REQ) state_n = FINISH;
      FINISH:  state_n = IDLE;
      DRAIN:   if (!AEROUT_REQ) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= IDLE;
      aerin_ack_q    <= 1'b0;
      NEW_IMAGE      <= 1'b0;
      INFERENCE_DONE <= 1'b0;
      AEROUT_ACK     <= 1'b0;
      RESULT         <= '0;
      RESULT_VALID   <= 1'b0;
      TIMED_OUT      <= 1'b0;
      SPIKE_COUNT    <= '0;
      LATENCY        <= '0;
    end else begin
      state          <= state_n;
      aerin_ack_q    <= AERIN_ACK;
      // pulses are registered off the next state so they coincide with that state
      NEW_IMAGE      <= (state_n == LAUNCH);
      INFERENCE_DONE <= (state_n == FINISH);
      AEROUT_ACK     <= (state_n == ACK_HI) || (state_n == DRAIN);
      if (spike_in && SPIKE_COUNT != 9'd511)
        SPIKE_COUNT <= SPIKE_COUNT + 9'd1;
      case (state)
        LAUNCH: begin
          SPIKE_COUNT  <= '0;
          LATENCY      <= '0;
          TIMED_OUT    <= 1'b0;
          RESULT_VALID <= 1'b0;
        end
        RUN: begin
          if (LATENCY != '1) LATENCY <= LATENCY + CNT_BITS'(1);
          if (AEROUT_REQ) RESULT <= AEROUT_ADDR;
          else if (timeout_hit) TIMED_OUT <= 1'b1;
        end
        FINISH:  RESULT_VALID <= !TIMED_OUT;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/inference_ctrl.md
INFERENCE_CTRL -- requirements
Module: inference_ctrl

Interface
REQ-001 Parameter ADDR_BITS, default 8, SHALL set the AER address width of AEROUT_ADDR and RESULT.
REQ-002 Parameter CNT_BITS, default 16, SHALL set the width of TIMEOUT_CYCLES and LATENCY.
REQ-003 The design SHALL use one clock; reset is synchronous and active-high.
REQ-004 Ports SHALL be:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- START  in  1  one-cycle host request to run one inference.
- TIMEOUT_CYCLES  in  CNT_BITS  run cycle limit; 0 = no limit.
- NEW_IMAGE  out  1  one-cycle start pulse to encoder.
- IMAGE_ENCODED  in  1  encoder status: all pixels sorted.
- INFERENCE_DONE  out  1  one-cycle stop pulse to encoder.
- AERIN_REQ  in  1  snooped encoder-to-core request; monitor only.
- AERIN_ACK  in  1  snooped encoder-to-core acknowledge; monitor only.
- AEROUT_REQ  in  1  core output-spike request, 4-phase.
- AEROUT_ADDR  in  ADDR_BITS  core output neuron ID.
- AEROUT_ACK  out  1  acknowledge to core.
- BUSY  out  1  high in any state except IDLE.
- RESULT  out  ADDR_BITS  winning neuron ID.
- RESULT_VALID  out  1  RESULT holds a classification.
- TIMED_OUT  out  1  last run ended by timeout.
- SPIKE_COUNT  out  9  input events delivered in the current or last run.
- LATENCY  out  CNT_BITS  cycles from NEW_IMAGE to first output request.

Function
REQ-005 The FSM SHALL have states IDLE, LAUNCH, RUN, ACK_HI, FINISH and DRAIN.
REQ-006 IDLE SHALL go to LAUNCH on START=1; on AEROUT_REQ=1 with START=0 it SHALL go to DRAIN; START has priority when both are high.
REQ-007 LAUNCH SHALL last 1 cycle, drive NEW_IMAGE=1, clear SPIKE_COUNT, LATENCY, TIMED_OUT and RESULT_VALID, then go to RUN.
REQ-008 RUN SHALL increment LATENCY every cycle, saturating at all-ones.
REQ-009 In RUN with AEROUT_REQ=1, RESULT SHALL capture AEROUT_ADDR, AEROUT_ACK SHALL be driven 1 from the next cycle, and the FSM SHALL go to ACK_HI.
REQ-010 In RUN with TIMEOUT_CYCLES!=0 and LATENCY==TIMEOUT_CYCLES-1, TIMED_OUT SHALL be set and the FSM SHALL go to FINISH.
REQ-011 If an AEROUT_REQ and the timeout occur in the same cycle, the spike SHALL win and TIMED_OUT SHALL stay 0.
REQ-012 ACK_HI SHALL hold AEROUT_ACK=1 until AEROUT_REQ is sampled 0, then deassert AEROUT_ACK in the same transition and go to FINISH.
REQ-013 FINISH SHALL last 1 cycle, drive INFERENCE_DONE=1, set RESULT_VALID=1 only if not timed out, then go to IDLE.
REQ-014 DRAIN SHALL acknowledge a stray output event with full 4-phase behaviour, leave RESULT, RESULT_VALID and all counters unchanged, then return to IDLE.
REQ-015 SPIKE_COUNT SHALL increment on each 0->1 transition of AERIN_ACK sampled while in RUN or ACK_HI.
REQ-016 SPIKE_COUNT SHALL saturate at 511.
REQ-017 The AERIN_ACK edge detector SHALL be one register.
REQ-018 START SHALL be ignored when not in IDLE.
REQ-019 IMAGE_ENCODED SHALL NOT end a run; the run continues until an output spike or the timeout.
REQ-020 RESULT, RESULT_VALID, TIMED_OUT, SPIKE_COUNT and LATENCY SHALL hold their values in IDLE until the next LAUNCH.
REQ-021 NEW_IMAGE, INFERENCE_DONE and AEROUT_ACK SHALL be registered outputs.

Reset
REQ-022 On RST=1 at a clock edge, the FSM SHALL go to IDLE and every output SHALL be 0, including RESULT, SPIKE_COUNT and LATENCY.
REQ-023 A reset mid-run SHALL drop AEROUT_ACK the following cycle, with no INFERENCE_DONE pulse.
REQ-024 START sampled in the cycle RST deasserts SHALL be honoured.

Verification
REQ-025 Normal run: TIMEOUT_CYCLES=1000, START pulse, core raises AEROUT_REQ with ADDR=7 after 40 run cycles, AERIN_ACK toggles 12 times -> exactly one NEW_IMAGE pulse, AEROUT_ACK 4-phase completes, exactly one INFERENCE_DONE pulse, RESULT=7, RESULT_VALID=1, LATENCY=40, SPIKE_COUNT=12, TIMED_OUT=0.
REQ-026 Timeout: TIMEOUT_CYCLES=50, no AEROUT_REQ -> INFERENCE_DONE 50 cycles after RUN entry, TIMED_OUT=1, RESULT_VALID=0.
REQ-027 Tie: AEROUT_REQ rises in the exact timeout cycle -> RESULT captured, TIMED_OUT=0.
REQ-028 Stray event: AEROUT_REQ pulse in IDLE with ADDR=3 -> acknowledged, RESULT and RESULT_VALID from the previous run unchanged, BUSY=1 only during DRAIN.
REQ-029 Saturation and ignored START: 600 AERIN_ACK pulses with TIMEOUT_CYCLES=0, plus a START pulse during RUN -> SPIKE_COUNT=511, no second NEW_IMAGE.
REQ-030 Reset mid-ACK_HI: RST asserted -> all outputs 0 next cycle, no INFERENCE_DONE, a subsequent START runs normally.
